btn_debounce_pulse: RTL and testbench

- Conditions the raw Nexys4 push-buttons (BtnU/BtnD/BtnL/BtnR) before they reach the game/block controller.
- Per button: 2-flop synchronizer, counter-based debouncer, single-cycle press pulse, auto-repeat pulse train while held, clean level output.
- Runs on the 100 MHz board clock. Sits between the top-level button pins and the movement logic, replacing direct raw-button use.

---
 rtl/btn_debounce_pulse.sv | 147 ++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: per channel a 2-flop synchronizer feeds a debounce FSM.
// The FSM produces a registered level, a single press pulse and an auto-repeat pulse train.
module btn_debounce_pulse #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_pressed
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAX_C);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_t;

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;

  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];
  logic [N_BTN-1:0] rep_sub_q;
  logic [N_BTN-1:0] rep_sub_d;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] pulse_d;
  logic [N_BTN-1:0] repeat_d;

  // Synchronizer stage: the FSM only ever looks at sync_p1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      rep_sub_d[i] = rep_sub_q[i];
      pulse_d[i]   = 1'b0;
      repeat_d[i]  = 1'b0;
      unique case (state_q[i])
        IDLE: begin
          if (sync_p1[i]) begin
            state_d[i] = DB_PRESS;
            cnt_d[i]   = '0;
          end
        end
        DB_PRESS: begin
          if (!sync_p1[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i]   = PRESSED;
            cnt_d[i]     = '0;
            rep_sub_d[i] = 1'b0;
            pulse_d[i]   = 1'b1;
            repeat_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          // rep_sub selects the long initial delay or the shorter repeat period.
          if (!sync_p1[i]) begin
            state_d[i] = DB_RELEASE;
            cnt_d[i]   = '0;
          end else if ((!rep_sub_q[i] && cnt_q[i] == RD_LAST) ||
                       ( rep_sub_q[i] && cnt_q[i] == RP_LAST)) begin
            cnt_d[i]     = '0;
            rep_sub_d[i] = 1'b1;
            repeat_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        DB_RELEASE: begin
          // A bounce back to pressed resumes repeating without a new press pulse.
          if (sync_p1[i]) begin
            state_d[i]   = PRESSED;
            cnt_d[i]     = '0;
            rep_sub_d[i] = 1'b1;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == DB_RELEASE);
    end
  end

  // FSM and output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      rep_sub_q   <= '0;
      btn_level   <= '0;
      btn_pulse   <= '0;
      btn_repeat  <= '0;
      any_pressed <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rep_sub_q   <= rep_sub_d;
      btn_level   <= level_d;
      btn_pulse   <= pulse_d;
      btn_repeat  <= repeat_d;
      any_pressed <= |level_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with short debounce/repeat parameters.
// Each scenario task compares {level, pulse, repeat, any} against hand-derived values per cycle.
module tb_btn_debounce_pulse;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic [N-1:0] btn_repeat;
  logic         any_pressed;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_l, exp_p, exp_r;
  logic         exp_a;
  logic [3*N:0] act_v, exp_v;
  int           pulse_cnt;

  btn_debounce_pulse #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_repeat(btn_repeat),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    btn_in = '1;
    idle(3);
    checks++;
    if ({btn_level, btn_pulse, btn_repeat, any_pressed} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %b want 0", {btn_level, btn_pulse, btn_repeat, any_pressed});
    end
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_p = (k == 7) ? '1 : '0;
      exp_l = (k >= 7) ? '1 : '0;
      exp_v = {exp_l, exp_p, exp_p, (k >= 7)};
      act_v = {btn_level, btn_pulse, btn_repeat, any_pressed};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_release k=%0d: got %b want %b", k, act_v, exp_v);
      end
    end
    btn_in = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_l = (k < 7) ? '1 : '0;
      exp_v = {exp_l, {N{1'b0}}, {N{1'b0}}, (k < 7)};
      act_v = {btn_level, btn_pulse, btn_repeat, any_pressed};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_all_release k=%0d: got %b want %b", k, act_v, exp_v);
      end
    end
    idle(3);
  endtask

  task automatic test_clean_press();
    btn_in = 5'b00001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_p = (k == 7) ? 5'b00001 : 5'b00000;
      exp_l = (k >= 7) ? 5'b00001 : 5'b00000;
      exp_v = {exp_l, exp_p, exp_p, (k >= 7)};
      act_v = {btn_level, btn_pulse, btn_repeat, any_pressed};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL clean_press k=%0d: got %b want %b", k, act_v, exp_v);
      end
    end
    btn_in = '0;
    idle(8);
    checks++;
    if ({btn_level, any_pressed} !== '0) begin
      errors++;
      $display("FAIL clean_release: got %b want 0", {btn_level, any_pressed});
    end
    idle(3);
  endtask

  task automatic test_glitch();
    btn_in = 5'b00100;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) btn_in = '0;
      act_v = {btn_level, btn_pulse, btn_repeat, any_pressed};
      checks++;
      if (act_v !== '0) begin
        errors++;
        $display("FAIL glitch k=%0d: got %b want 0", k, act_v);
      end
    end
  endtask

  task automatic test_auto_repeat();
    int j;
    btn_in    = 5'b00010;
    pulse_cnt = 0;
    for (int k = 1; k <= 47; k++) begin
      tick();
      j     = k - 7;
      exp_p = (j == 0) ? 5'b00010 : 5'b00000;
      exp_r = (j == 0 || (j >= 10 && j % 5 == 0)) ? 5'b00010 : 5'b00000;
      exp_l = (j >= 0) ? 5'b00010 : 5'b00000;
      exp_v = {exp_l, exp_p, exp_r, (j >= 0)};
      act_v = {btn_level, btn_pulse, btn_repeat, any_pressed};
      if (btn_pulse[1]) pulse_cnt++;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL auto_repeat j=%0d: got %b want %b", j, act_v, exp_v);
      end
    end
    checks++;
    if (pulse_cnt != 1) begin
      errors++;
      $display("FAIL auto_repeat_pulse_count: got %0d want 1", pulse_cnt);
    end
    btn_in = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_l = (k < 7) ? 5'b00010 : 5'b00000;
      checks++;
      if ({btn_level, btn_pulse} !== {exp_l, 5'b00000}) begin
        errors++;
        $display("FAIL auto_repeat_release k=%0d: got %b want %b", k, {btn_level, btn_pulse}, {exp_l, 5'b00000});
      end
    end
    idle(3);
  endtask

  task automatic test_release_bounce();
    btn_in = 5'b01000;
    idle(6);
    tick();
    checks++;
    if ({btn_level, btn_pulse} !== {5'b01000, 5'b01000}) begin
      errors++;
      $display("FAIL bounce_press: got %b want %b", {btn_level, btn_pulse}, {5'b01000, 5'b01000});
    end
    tick();
    btn_in = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) btn_in = 5'b01000;
      checks++;
      if ({btn_level, btn_pulse, any_pressed} !== {5'b01000, 5'b00000, 1'b1}) begin
        errors++;
        $display("FAIL bounce_hold k=%0d: got %b want %b", k, {btn_level, btn_pulse, any_pressed}, {5'b01000, 5'b00000, 1'b1});
      end
    end
    btn_in = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_l = (k < 7) ? 5'b01000 : 5'b00000;
      checks++;
      if ({btn_level, btn_pulse, any_pressed} !== {exp_l, 5'b00000, (k < 7)}) begin
        errors++;
        $display("FAIL bounce_release k=%0d: got %b want %b", k, {btn_level, btn_pulse, any_pressed}, {exp_l, 5'b00000, (k < 7)});
      end
    end
    idle(3);
  endtask

  task automatic test_mid_reset();
    btn_in = 5'b10000;
    idle(4);
    rst = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_pulse, btn_repeat, any_pressed} !== '0) begin
      errors++;
      $display("FAIL mid_reset_assert: got %b want 0", {btn_level, btn_pulse, btn_repeat, any_pressed});
    end
    idle(2);
    rst       = 1'b1;
    pulse_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_p = (k == 7) ? 5'b10000 : 5'b00000;
      exp_l = (k >= 7) ? 5'b10000 : 5'b00000;
      exp_v = {exp_l, exp_p, exp_p, (k >= 7)};
      act_v = {btn_level, btn_pulse, btn_repeat, any_pressed};
      if (btn_pulse[4]) pulse_cnt++;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL mid_reset_requalify k=%0d: got %b want %b", k, act_v, exp_v);
      end
    end
    checks++;
    if (pulse_cnt != 1) begin
      errors++;
      $display("FAIL mid_reset_pulse_count: got %0d want 1", pulse_cnt);
    end
    btn_in = '0;
    idle(10);
  endtask

  initial begin
    rst    = 1'b0;
    btn_in = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_release_bounce();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
